// File: rtl/bsg_arb_pkg.sv
// bsg_arb_pkg: shared state encoding and sizing helper for the round-robin arbiters
package bsg_arb_pkg;
  typedef enum logic {eIDLE, eGRANT} bsg_arb_state_e;
  function automatic int bsg_rr_id_width(input int width_p);
    return (width_p > 1) ? $clog2(width_p) : 1;
  endfunction
endpackage

// File: rtl/bsg_rr_pick_one_hot.sv
// bsg_rr_pick_one_hot: one-hot round-robin pick of r_i starting one position past last_i
module bsg_rr_pick_one_hot #(
  parameter int width_p    = 4,
  parameter bit lo_to_hi_p = 1'b1
) (
  input  logic [width_p-1:0] r_i,
  input  logic [width_p-1:0] last_i,
  output logic [width_p-1:0] grant_o
);
  logic [width_p-1:0] r_o, l_o, m, pick;
  // Downward search is the upward search on bit-reversed vectors.
  for (genvar j = 0; j < width_p; j++) begin : g_o
    assign r_o[j]     = r_i[lo_to_hi_p ? j : width_p-1-j];
    assign l_o[j]     = last_i[lo_to_hi_p ? j : width_p-1-j];
    assign grant_o[j] = pick[lo_to_hi_p ? j : width_p-1-j];
  end
  assign m    = r_o & ~((l_o << 1) - width_p'(1));
  assign pick = |m ? m & (~m + width_p'(1)) : r_o & (~r_o + width_p'(1));
endmodule

// File: rtl/bsg_rr_arb_one_hot_hold.sv
// bsg_rr_arb_one_hot_hold: round-robin arbiter with a registered one-hot grant held until yumi
module bsg_rr_arb_one_hot_hold
  import bsg_arb_pkg::*;
#(
  parameter  int width_p    = 4,
  parameter  bit lo_to_hi_p = 1'b1,
  localparam int id_w_lp    = bsg_rr_id_width(width_p)
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [width_p-1:0] reqs_i,
  output logic               v_o,
  output logic [width_p-1:0] grant_one_hot_o,
  output logic [id_w_lp-1:0] grant_id_o,
  input  logic               yumi_i
);
  localparam logic [width_p-1:0] last_rst_lp = width_p'(1) << (lo_to_hi_p ? width_p-1 : 0);
  bsg_arb_state_e state_q, state_d;
  logic [width_p-1:0] grant_q, grant_d, last_q, last_d, pick;
  logic [id_w_lp-1:0] id_q, id_d, pick_id;
  logic accept, load;
  bsg_rr_pick_one_hot #(.width_p(width_p), .lo_to_hi_p(lo_to_hi_p)) u_pick (
    .r_i(reqs_i), .last_i(last_d), .grant_o(pick)
  );
  for (genvar b = 0; b < id_w_lp; b++) begin : g_e
    logic [width_p-1:0] sel;
    for (genvar j = 0; j < width_p; j++) begin : g_s
      assign sel[j] = ((j >> b) & 1) == 1;
    end
    assign pick_id[b] = |(pick & sel);
  end
  // Reload grant from idle or on acceptance; the pick already sees the updated pointer.
  always_comb begin
    accept  = (state_q == eGRANT) & yumi_i;
    load    = (state_q == eIDLE) | accept;
    last_d  = accept ? grant_q : last_q;
    state_d = load ? (|reqs_i ? eGRANT : eIDLE) : state_q;
    grant_d = load ? pick : grant_q;
    id_d    = load ? pick_id : id_q;
  end
  // State, grant, index and pointer registers; reset drops the grant at once.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= eIDLE;
      grant_q <= '0;
      id_q    <= '0;
      last_q  <= last_rst_lp;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      id_q    <= id_d;
      last_q  <= last_d;
    end
  end
  assign v_o             = state_q == eGRANT;
  assign grant_one_hot_o = grant_q & {width_p{v_o}};
  assign grant_id_o      = id_q;
  a_onehot: assert property (@(posedge clk_i) disable iff (reset_i) $onehot0(grant_one_hot_o));
  a_valid:  assert property (@(posedge clk_i) disable iff (reset_i) v_o == |grant_one_hot_o);
  a_hold:   assert property (@(posedge clk_i) disable iff (reset_i) v_o & ~yumi_i |=> $stable(grant_one_hot_o));
  a_yumi:   assert property (@(posedge clk_i) disable iff (reset_i) yumi_i |-> v_o);
endmodule

// File: tb/tb_bsg_rr_arb_one_hot_hold.sv
// tb_bsg_rr_arb_one_hot_hold: scoreboard bench for both search directions of the arbiter
module tb_bsg_rr_arb_one_hot_hold;
  logic clk = 1'b0, rst = 1'b1;
  logic [3:0] reqs_a = '0, reqs_b = '0, g_a, g_b;
  logic yumi_a = 1'b0, yumi_b = 1'b0, v_a, v_b;
  logic [1:0] id_a, id_b;
  typedef struct {bit b; bit v; logic [3:0] g;} exp_t;
  exp_t q[$];
  exp_t e;
  int errs = 0, checks = 0;
  int waits[4] = '{0, 0, 0, 0};
  bit rnd = 1'b0;
  always #5 clk = ~clk;
  bsg_rr_arb_one_hot_hold #(.width_p(4), .lo_to_hi_p(1'b1)) dut_a (
    .clk_i(clk), .reset_i(rst), .reqs_i(reqs_a), .v_o(v_a),
    .grant_one_hot_o(g_a), .grant_id_o(id_a), .yumi_i(yumi_a)
  );
  bsg_rr_arb_one_hot_hold #(.width_p(4), .lo_to_hi_p(1'b0)) dut_b (
    .clk_i(clk), .reset_i(rst), .reqs_i(reqs_b), .v_o(v_b),
    .grant_one_hot_o(g_b), .grant_id_o(id_b), .yumi_i(yumi_b)
  );
  function automatic logic [1:0] enc(input logic [3:0] g);
    return {g[3] | g[2], g[3] | g[1]};
  endfunction
  task automatic chk(input string n, input logic [6:0] act, input logic [6:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got v/id/grant=%b/%b/%b, expected %b/%b/%b", n,
               act[6], act[5:4], act[3:0], exp[6], exp[5:4], exp[3:0]);
    end
  endtask
  task automatic cyc(input bit b, input logic [3:0] r, input bit y, input bit ev, input logic [3:0] eg);
    @(posedge clk);
    #1;
    q.push_back('{b, ev, eg});
    if (b) begin
      reqs_b = r;
      yumi_b = y;
    end else begin
      reqs_a = r;
      yumi_a = y;
    end
  endtask
  task automatic do_reset;
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("async_reset_a", {v_a, id_a, g_a}, 7'b0);
    chk("async_reset_b", {v_b, id_b, g_b}, 7'b0);
    @(posedge clk);
    #3 rst = 1'b0;
  endtask
  always @(negedge clk) begin
    if (q.size() > 0) begin
      e = q.pop_front();
      chk(e.b ? "grant_b" : "grant_a", e.b ? {v_b, id_b, g_b} : {v_a, id_a, g_a},
          {e.v, enc(e.g), e.g});
    end else if (rnd && v_a && yumi_a) begin
      for (int i = 0; i < 4; i++) begin
        if (g_a[i] || !reqs_a[i]) waits[i] = 0;
        else waits[i]++;
        checks++;
        if (waits[i] > 4) begin
          errs++;
          $display("FAIL fairness req%0d: waited %0d accepted grants, limit 4", i, waits[i]);
        end
      end
    end
  end
  initial begin
    #2;
    chk("reset_a", {v_a, id_a, g_a}, 7'b0);
    chk("reset_b", {v_b, id_b, g_b}, 7'b0);
    @(posedge clk);
    #3 rst = 1'b0;
    cyc(0, 4'b1111, 0, 0, 4'b0000);
    cyc(0, 4'b1111, 1, 1, 4'b0001);
    cyc(0, 4'b1111, 1, 1, 4'b0010);
    cyc(0, 4'b1111, 1, 1, 4'b0100);
    cyc(0, 4'b1111, 1, 1, 4'b1000);
    cyc(0, 4'b0000, 1, 1, 4'b0001);
    cyc(0, 4'b0000, 0, 0, 4'b0000);
    do_reset();
    cyc(0, 4'b0101, 0, 0, 4'b0000);
    repeat (4) cyc(0, 4'b0101, 0, 1, 4'b0001);
    cyc(0, 4'b0000, 0, 1, 4'b0001);
    cyc(0, 4'b0000, 1, 1, 4'b0001);
    cyc(0, 4'b0000, 0, 0, 4'b0000);
    cyc(0, 4'b0101, 0, 0, 4'b0000);
    cyc(0, 4'b0000, 1, 1, 4'b0100);
    cyc(0, 4'b0101, 0, 0, 4'b0000);
    cyc(0, 4'b0000, 1, 1, 4'b0001);
    cyc(0, 4'b0000, 0, 0, 4'b0000);
    cyc(0, 4'b1000, 0, 0, 4'b0000);
    repeat (3) cyc(0, 4'b1000, 1, 1, 4'b1000);
    cyc(0, 4'b0000, 1, 1, 4'b1000);
    cyc(0, 4'b0000, 0, 0, 4'b0000);
    cyc(0, 4'b1001, 0, 0, 4'b0000);
    cyc(0, 4'b1001, 0, 1, 4'b0001);
    do_reset();
    cyc(0, 4'b1001, 1, 1, 4'b0001);
    cyc(0, 4'b0000, 1, 1, 4'b1000);
    cyc(0, 4'b0000, 0, 0, 4'b0000);
    cyc(1, 4'b1111, 0, 0, 4'b0000);
    cyc(1, 4'b1111, 1, 1, 4'b1000);
    cyc(1, 4'b1111, 1, 1, 4'b0100);
    cyc(1, 4'b1111, 1, 1, 4'b0010);
    cyc(1, 4'b1111, 1, 1, 4'b0001);
    cyc(1, 4'b0000, 1, 1, 4'b1000);
    cyc(1, 4'b0000, 0, 0, 4'b0000);
    cyc(1, 4'b0101, 0, 0, 4'b0000);
    cyc(1, 4'b0000, 1, 1, 4'b0100);
    cyc(1, 4'b0101, 0, 0, 4'b0000);
    cyc(1, 4'b0000, 1, 1, 4'b0001);
    cyc(1, 4'b0000, 0, 0, 4'b0000);
    @(posedge clk);
    #1 rnd = 1'b1;
    repeat (10000) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) if ($urandom_range(7) == 0) reqs_a[i] = ~reqs_a[i];
      yumi_a = v_a && ($urandom_range(1) == 1);
    end
    @(posedge clk);
    #1;
    rnd = 1'b0;
    reqs_a = '0;
    yumi_a = 1'b0;
    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
